// File: rtl/accelbrot_pkg.sv
// Shared types for the accelbrot AXI RAM: read/write channel state encodings
// and the fixed OKAY response code.
package accelbrot_pkg;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FETCH = 2'd1,
    R_DATA  = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/accelbrot_ram_dp.sv
// Simple dual-port RAM: one byte-enabled write port, one read port with a
// single cycle of latency. A read and write of the same word return old data.
module accelbrot_ram_dp #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 4096,
  parameter int STRB_W = DATA_W / 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Read output only updates when re is high, so it holds the last fetch.
  always_ff @(posedge clk) begin
    if (re) rdata_q <= mem_q[raddr];
    if (we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/accelbrot_axi_ram.sv
// AXI4 slave RAM supporting full-width INCR bursts, with independent read
// and write state machines sharing a read-first dual-port RAM.
module accelbrot_axi_ram
  import accelbrot_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 128,
  parameter int MEM_DEPTH      = 4096,
  parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [AXI_ADDR_WIDTH-1:0] wram_araddr,
  input  logic [7:0]                wram_arlen,
  input  logic                      wram_arvalid,
  output logic                      wram_arready,
  output logic [AXI_DATA_WIDTH-1:0] wram_rdata,
  output logic                      wram_rlast,
  output logic [1:0]                wram_rresp,
  output logic                      wram_rvalid,
  input  logic                      wram_rready,
  input  logic [AXI_ADDR_WIDTH-1:0] wram_awaddr,
  input  logic [7:0]                wram_awlen,
  input  logic                      wram_awvalid,
  output logic                      wram_awready,
  input  logic [AXI_DATA_WIDTH-1:0] wram_wdata,
  input  logic [AXI_STRB_WIDTH-1:0] wram_wstrb,
  input  logic                      wram_wlast,
  input  logic                      wram_wvalid,
  output logic                      wram_wready,
  output logic [1:0]                wram_bresp,
  output logic                      wram_bvalid,
  input  logic                      wram_bready
);

  localparam int OFF_W = $clog2(AXI_STRB_WIDTH);
  localparam int IDX_W = $clog2(MEM_DEPTH);

  rd_state_e        rd_state_q;
  wr_state_e        wr_state_q;
  logic [IDX_W-1:0] rd_idx_q, wr_idx_q;
  logic [7:0]       rd_len_q, rd_cnt_q, wr_len_q, wr_cnt_q;
  logic             arready_q, rvalid_q, rlast_q;
  logic             awready_q, wready_q, bvalid_q;
  logic             ram_re, ram_we;

  // Byte offset and bits above the RAM depth are intentionally discarded;
  // wlast is informational because the beat counter ends the burst.
  logic unused_ok;
  assign unused_ok = ^{wram_araddr, wram_awaddr, wram_wlast};

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
    end else begin
      case (rd_state_q)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (wram_arvalid && arready_q) begin
            rd_idx_q   <= wram_araddr[OFF_W +: IDX_W];
            rd_len_q   <= wram_arlen;
            rd_cnt_q   <= 8'd0;
            arready_q  <= 1'b0;
            rd_state_q <= R_FETCH;
          end
        end
        R_FETCH: begin
          rvalid_q   <= 1'b1;
          rlast_q    <= (rd_cnt_q == rd_len_q);
          rd_state_q <= R_DATA;
        end
        R_DATA: begin
          if (wram_rready) begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            if (rlast_q) begin
              arready_q  <= 1'b1;
              rd_state_q <= R_IDLE;
            end else begin
              rd_idx_q   <= rd_idx_q + 1'b1;
              rd_cnt_q   <= rd_cnt_q + 8'd1;
              rd_state_q <= R_FETCH;
            end
          end
        end
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_state_q <= W_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
    end else begin
      case (wr_state_q)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (wram_awvalid && awready_q) begin
            wr_idx_q   <= wram_awaddr[OFF_W +: IDX_W];
            wr_len_q   <= wram_awlen;
            wr_cnt_q   <= 8'd0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b1;
            wr_state_q <= W_DATA;
          end
        end
        W_DATA: begin
          if (wram_wvalid && wready_q) begin
            if (wr_cnt_q == wr_len_q) begin
              wready_q   <= 1'b0;
              bvalid_q   <= 1'b1;
              wr_state_q <= W_RESP;
            end else begin
              wr_idx_q <= wr_idx_q + 1'b1;
              wr_cnt_q <= wr_cnt_q + 8'd1;
            end
          end
        end
        W_RESP: begin
          if (wram_bready) begin
            bvalid_q   <= 1'b0;
            awready_q  <= 1'b1;
            wr_state_q <= W_IDLE;
          end
        end
        default: wr_state_q <= W_IDLE;
      endcase
    end
  end

  // Gating with rstn keeps an abandoned burst from touching memory.
  assign ram_re = (rd_state_q == R_FETCH);
  assign ram_we = rstn && (wr_state_q == W_DATA) && wram_wvalid && wready_q;

  accelbrot_ram_dp #(
    .DATA_W (AXI_DATA_WIDTH),
    .DEPTH  (MEM_DEPTH),
    .STRB_W (AXI_STRB_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_idx_q),
    .wdata (wram_wdata),
    .wstrb (wram_wstrb),
    .re    (ram_re),
    .raddr (rd_idx_q),
    .rdata (wram_rdata)
  );

  assign wram_arready = arready_q;
  assign wram_rvalid  = rvalid_q;
  assign wram_rlast   = rlast_q;
  assign wram_rresp   = RESP_OKAY;
  assign wram_awready = awready_q;
  assign wram_wready  = wready_q;
  assign wram_bvalid  = bvalid_q;
  assign wram_bresp   = RESP_OKAY;

endmodule

// File: tb/tb_accelbrot_axi_ram.sv
// Bench for accelbrot_axi_ram: directed table, burst/boundary sequences and
// randomized bursts checked against a word-array model of the memory.
module tb_accelbrot_axi_ram;

  localparam int AW    = 32;
  localparam int DW    = 128;
  localparam int DEPTH = 4096;
  localparam int SW    = DW / 8;
  localparam int TMO   = 300;

  logic          clk = 1'b0;
  logic          rstn;
  logic [AW-1:0] araddr, awaddr;
  logic [7:0]    arlen, awlen;
  logic          arvalid, arready, rlast, rvalid, rready;
  logic [DW-1:0] rdata, wdata;
  logic [1:0]    rresp, bresp;
  logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [SW-1:0] wstrb;

  accelbrot_axi_ram #(
    .AXI_ADDR_WIDTH (AW),
    .AXI_DATA_WIDTH (DW),
    .MEM_DEPTH      (DEPTH),
    .AXI_STRB_WIDTH (SW)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .wram_araddr  (araddr),
    .wram_arlen   (arlen),
    .wram_arvalid (arvalid),
    .wram_arready (arready),
    .wram_rdata   (rdata),
    .wram_rlast   (rlast),
    .wram_rresp   (rresp),
    .wram_rvalid  (rvalid),
    .wram_rready  (rready),
    .wram_awaddr  (awaddr),
    .wram_awlen   (awlen),
    .wram_awvalid (awvalid),
    .wram_awready (awready),
    .wram_wdata   (wdata),
    .wram_wstrb   (wstrb),
    .wram_wlast   (wlast),
    .wram_wvalid  (wvalid),
    .wram_wready  (wready),
    .wram_bresp   (bresp),
    .wram_bvalid  (bvalid),
    .wram_bready  (bready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Memory model: one entry per word, plus a flag for words with defined content.
  logic [DW-1:0] mem_m   [DEPTH];
  bit            known_m [DEPTH];

  logic [DW-1:0] wbuf [256];
  logic [SW-1:0] sbuf [256];
  logic [DW-1:0] rbuf [256];

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic [DW-1:0] exp;
  } vec_t;
  vec_t tbl [5];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int word_of(input logic [AW-1:0] addr, input int beat);
    return ((int'(addr) / SW) + beat) % DEPTH;
  endfunction

  task automatic wait_high(input string name, ref logic sig);
    int n = 0;
    while (sig !== 1'b1 && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (sig !== 1'b1) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic axi_write(input logic [AW-1:0] addr, input int len, input int bdelay);
    awaddr = addr; awlen = 8'(len); awvalid = 1'b1;
    wait_high("awready", awready);
    @(negedge clk);
    awvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      wdata = wbuf[b]; wstrb = sbuf[b]; wlast = (b == len); wvalid = 1'b1;
      wait_high("wready", wready);
      @(negedge clk);
      wvalid = 1'b0; wlast = 1'b0;
      for (int k = 0; k < SW; k++)
        if (sbuf[b][k]) mem_m[word_of(addr, b)][8*k +: 8] = wbuf[b][8*k +: 8];
      if (&sbuf[b]) known_m[word_of(addr, b)] = 1'b1;
    end
    wait_high("bvalid", bvalid);
    chk("bresp", DW'(bresp), 0);
    for (int d = 0; d < bdelay; d++) begin
      @(negedge clk);
      chk("bvalid_hold", DW'(bvalid), 1);
      chk("awready_during_resp", DW'(awready), 0);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, input int len, input int rdelay);
    logic [DW-1:0] first;
    araddr = addr; arlen = 8'(len); arvalid = 1'b1;
    wait_high("arready", arready);
    @(negedge clk);
    arvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      wait_high("rvalid", rvalid);
      rbuf[b] = rdata;
      first   = rdata;
      if (known_m[word_of(addr, b)]) chk("rdata_model", rdata, mem_m[word_of(addr, b)]);
      chk("rlast", DW'(rlast), DW'(b == len));
      chk("rresp", DW'(rresp), 0);
      for (int d = 0; d < rdelay; d++) begin
        @(negedge clk);
        chk("rvalid_hold", DW'(rvalid), 1);
        chk("rdata_hold", rdata, first);
      end
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
    end
  endtask

  initial begin
    logic [DW-1:0] old_v, new_v;
    rstn = 1'b0;
    araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
    awaddr = '0; awlen = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;

    tbl[0] = '{32'h10, {16{8'hAA}}, 16'hFFFF, {16{8'hAA}}};
    tbl[1] = '{32'h30, '0, 16'hFFFF, '0};
    tbl[2] = '{32'h30, 128'hFF, 16'h0001, 128'hFF};
    tbl[3] = '{32'h30, {16{8'h11}}, 16'h8000, {8'h11, 104'h0, 8'h00, 8'hFF}};
    tbl[4] = '{32'h3F, {16{8'h22}}, 16'h0002, {8'h11, 104'h0, 8'h22, 8'hFF}};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_arready", DW'(arready), 0);
    chk("rst_awready", DW'(awready), 0);
    chk("rst_wready",  DW'(wready),  0);
    chk("rst_rvalid",  DW'(rvalid),  0);
    chk("rst_rlast",   DW'(rlast),   0);
    chk("rst_bvalid",  DW'(bvalid),  0);
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_arready", DW'(arready), 1);
    chk("post_rst_awready", DW'(awready), 1);

    // Single-beat table: write, read back, compare to literal expectation
    for (int i = 0; i < 5; i++) begin
      wbuf[0] = tbl[i].wdata; sbuf[0] = tbl[i].wstrb;
      axi_write(tbl[i].addr, 0, 0);
      axi_read(tbl[i].addr, 0, 0);
      chk("tbl_rdata", rbuf[0], tbl[i].exp);
    end

    // Four-beat burst
    for (int b = 0; b < 4; b++) begin wbuf[b] = DW'(b + 1); sbuf[b] = '1; end
    axi_write(32'h100, 3, 0);
    axi_read(32'h100, 3, 1);
    for (int b = 0; b < 4; b++) chk("burst4_rdata", rbuf[b], DW'(b + 1));

    // Wrap from the last word to word 0, with bready and rready held off
    wbuf[0] = DW'(7); wbuf[1] = DW'(8); sbuf[0] = '1; sbuf[1] = '1;
    axi_write(AW'((DEPTH - 1) * SW), 1, 5);
    axi_read(32'h0, 0, 5);
    chk("wrap_word0", rbuf[0], DW'(8));
    axi_read(AW'((DEPTH - 1) * SW), 0, 0);
    chk("wrap_last", rbuf[0], DW'(7));

    // Same-cycle read and write of one word returns the old value
    old_v = {4{32'hCAFE_0001}};
    new_v = {4{32'hBEEF_0002}};
    wbuf[0] = old_v; sbuf[0] = '1;
    axi_write(32'h400, 0, 0);
    awaddr = 32'h400; awlen = 8'd0; awvalid = 1'b1;
    wait_high("awready", awready);
    @(negedge clk);
    awvalid = 1'b0;
    araddr = 32'h400; arlen = 8'd0; arvalid = 1'b1;
    wait_high("arready", arready);
    @(negedge clk);
    arvalid = 1'b0;
    wdata = new_v; wstrb = '1; wlast = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0;
    wait_high("rvalid", rvalid);
    chk("read_first_old", rdata, old_v);
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    wait_high("bvalid", bvalid);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    mem_m[32'h40] = new_v;
    axi_read(32'h400, 0, 0);
    chk("read_first_new", rbuf[0], new_v);

    // Reset in the middle of a read burst
    araddr = 32'h100; arlen = 8'd3; arvalid = 1'b1;
    wait_high("arready", arready);
    @(negedge clk);
    arvalid = 1'b0;
    wait_high("rvalid", rvalid);
    chk("midrst_beat0", rdata, DW'(1));
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    wait_high("rvalid", rvalid);
    rstn = 1'b0;
    @(negedge clk);
    chk("midrst_rvalid", DW'(rvalid), 0);
    chk("midrst_arready", DW'(arready), 0);
    rstn = 1'b1;
    @(negedge clk);
    chk("midrst_arready_back", DW'(arready), 1);
    axi_read(32'h100, 3, 0);
    for (int b = 0; b < 4; b++) chk("after_rst_rdata", rbuf[b], DW'(b + 1));

    // Maximum length burst wrapping past the top of memory
    for (int b = 0; b < 256; b++) begin
      wbuf[b] = {$urandom, $urandom, $urandom, $urandom};
      sbuf[b] = '1;
    end
    axi_write(AW'((DEPTH - 100) * SW), 255, 0);
    axi_read(AW'((DEPTH - 100) * SW), 255, 0);
    chk("len255_last", rbuf[255], wbuf[255]);

    // Randomized bursts, strobes and handshake delays
    for (int it = 0; it < 25; it++) begin
      logic [AW-1:0] a;
      int len;
      a   = AW'($urandom_range(0, DEPTH - 1) * SW + $urandom_range(0, SW - 1));
      len = $urandom_range(0, 7);
      for (int b = 0; b <= len; b++) begin
        wbuf[b] = {$urandom, $urandom, $urandom, $urandom};
        sbuf[b] = known_m[word_of(a, b)] ? SW'($urandom) : '1;
      end
      axi_write(a, len, $urandom_range(0, 2));
      axi_read(a, len, $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
